// File: rtl/xyzw_mac_sequencer.sv
// Control sequencer for the XYZW operand-select stage: serial RND chain loader
// plus OPMODE sequencing for N-term multiply-accumulate jobs with optional rounding.
module xyzw_mac_sequencer #(
    parameter int CFG_WIDTH = 48,
    parameter int LEN_WIDTH = 8,
    parameter int PIPE_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_load,
    input  logic [CFG_WIDTH-1:0] cfg_word,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic [CFG_WIDTH-1:0] cfg_prev,
    output logic                 cfg_loaded,
    output logic                 cfg_shift_en,
    output logic                 cfg_serial_out,
    input  logic                 cfg_serial_in,
    input  logic                 job_start,
    input  logic [LEN_WIDTH-1:0] job_len,
    input  logic                 job_round,
    output logic                 job_ready,
    output logic                 job_err,
    output logic [8:0]           opmode,
    output logic                 operand_take,
    output logic                 result_valid
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CFG_SHIFT = 3'd1;
    localparam logic [2:0] S_MAC_FIRST = 3'd2;
    localparam logic [2:0] S_MAC_ACC   = 3'd3;
    localparam logic [2:0] S_ROUND     = 3'd4;
    localparam logic [2:0] S_DRAIN     = 3'd5;

    localparam logic [8:0] OP_HOLD  = 9'h020;
    localparam logic [8:0] OP_FIRST = 9'h005;
    localparam logic [8:0] OP_ACC   = 9'h025;
    localparam logic [8:0] OP_ROUND = 9'h120;

    localparam int CFG_CNT_W   = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    localparam int DRAIN_CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CFG_CNT_W-1:0]   CFG_LAST   = CFG_CNT_W'(CFG_WIDTH - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(PIPE_LAT - 1);

    logic [2:0]             state_q,     state_d;
    logic [CFG_CNT_W-1:0]   cfg_cnt_q,   cfg_cnt_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [LEN_WIDTH-1:0]   rem_q,       rem_d;
    logic                   round_q,     round_d;
    logic [CFG_WIDTH-1:0]   sreg_q,      sreg_d;
    logic [CFG_WIDTH-1:0]   prev_q,      prev_d;
    logic                   loaded_q,    loaded_d;
    logic [8:0]             opmode_q,    opmode_d;
    logic                   shift_en_q,  shift_en_d;
    logic                   take_q,      take_d;
    logic                   ready_q,     ready_d;
    logic                   done_q,      done_d;
    logic                   err_q,       err_d;
    logic                   valid_q,     valid_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d     = state_q;
        cfg_cnt_d   = cfg_cnt_q;
        drain_cnt_d = drain_cnt_q;
        rem_d       = rem_q;
        round_d     = round_q;
        sreg_d      = sreg_q;
        prev_d      = prev_q;
        loaded_d    = loaded_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    state_d   = S_CFG_SHIFT;
                    sreg_d    = cfg_word;
                    cfg_cnt_d = '0;
                end else if (job_start) begin
                    if (job_len == '0 || (job_round && !loaded_q)) begin
                        err_d = 1'b1;
                    end else begin
                        // Remaining MAC_ACC cycles after MAC_FIRST; never wraps for any job_len >= 1.
                        rem_d   = job_len - 1'b1;
                        round_d = job_round;
                        state_d = S_MAC_FIRST;
                    end
                end
            end
            S_CFG_SHIFT: begin
                sreg_d = sreg_q << 1;
                prev_d = {prev_q[CFG_WIDTH-2:0], cfg_serial_in};
                if (cfg_cnt_q == CFG_LAST) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    loaded_d = 1'b1;
                end else begin
                    cfg_cnt_d = cfg_cnt_q + 1'b1;
                end
            end
            S_MAC_FIRST, S_MAC_ACC: begin
                if (rem_q == '0) begin
                    state_d     = round_q ? S_ROUND : S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    rem_d   = rem_q - 1'b1;
                    state_d = S_MAC_ACC;
                end
            end
            S_ROUND: begin
                state_d     = S_DRAIN;
                drain_cnt_d = '0;
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are valid in the state they describe.
        case (state_d)
            S_MAC_FIRST: opmode_d = OP_FIRST;
            S_MAC_ACC:   opmode_d = OP_ACC;
            S_ROUND:     opmode_d = OP_ROUND;
            default:     opmode_d = OP_HOLD;
        endcase
        shift_en_d = (state_d == S_CFG_SHIFT);
        take_d     = (state_d == S_MAC_FIRST) || (state_d == S_MAC_ACC);
        ready_d    = (state_d == S_IDLE);
        valid_d    = (state_d == S_DRAIN) && (drain_cnt_d == DRAIN_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cfg_cnt_q   <= '0;
            drain_cnt_q <= '0;
            rem_q       <= '0;
            round_q     <= 1'b0;
            sreg_q      <= '0;
            prev_q      <= '0;
            loaded_q    <= 1'b0;
            opmode_q    <= OP_HOLD;
            shift_en_q  <= 1'b0;
            take_q      <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_cnt_q   <= cfg_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            rem_q       <= rem_d;
            round_q     <= round_d;
            sreg_q      <= sreg_d;
            prev_q      <= prev_d;
            loaded_q    <= loaded_d;
            opmode_q    <= opmode_d;
            shift_en_q  <= shift_en_d;
            take_q      <= take_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
        end
    end

    assign cfg_busy       = shift_en_q;
    assign cfg_shift_en   = shift_en_q;
    assign cfg_serial_out = sreg_q[CFG_WIDTH-1];
    assign cfg_done       = done_q;
    assign cfg_prev       = prev_q;
    assign cfg_loaded     = loaded_q;
    assign job_ready      = ready_q;
    assign job_err        = err_q;
    assign opmode         = opmode_q;
    assign operand_take   = take_q;
    assign result_valid   = valid_q;

endmodule

// File: tb/tb_xyzw_mac_sequencer.sv
// Scoreboard bench for xyzw_mac_sequencer: requests push expected outcomes,
// a negedge monitor pops and checks them as the DUT reports completions.
module tb_xyzw_mac_sequencer;

    localparam int CW = 48;
    localparam int LW = 8;
    localparam int PL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_load = 1'b0;
    logic [CW-1:0] cfg_word = '0;
    logic          cfg_busy, cfg_done, cfg_loaded, cfg_shift_en, cfg_serial_out, cfg_serial_in;
    logic [CW-1:0] cfg_prev;
    logic          job_start = 1'b0;
    logic [LW-1:0] job_len = '0;
    logic          job_round = 1'b0;
    logic          job_ready, job_err, operand_take, result_valid;
    logic [8:0]    opmode;

    always #5 clk = ~clk;

    xyzw_mac_sequencer #(.CFG_WIDTH(CW), .LEN_WIDTH(LW), .PIPE_LAT(PL)) dut (
        .clk(clk), .reset(reset),
        .cfg_load(cfg_load), .cfg_word(cfg_word), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_prev(cfg_prev), .cfg_loaded(cfg_loaded), .cfg_shift_en(cfg_shift_en),
        .cfg_serial_out(cfg_serial_out), .cfg_serial_in(cfg_serial_in),
        .job_start(job_start), .job_len(job_len), .job_round(job_round),
        .job_ready(job_ready), .job_err(job_err), .opmode(opmode),
        .operand_take(operand_take), .result_valid(result_valid)
    );

    // Stand-in for the XYZW stage configuration chain (MSB feeds configuration_output).
    logic [CW-1:0] chain;
    assign cfg_serial_in = chain[CW-1];
    always @(posedge clk) if (cfg_shift_en) chain <= {chain[CW-2:0], cfg_serial_out};

    int tests = 0;
    int fails = 0;

    typedef struct { int len; bit rnd; } job_t;
    typedef struct { logic [CW-1:0] word; logic [CW-1:0] prev; bit chk; } cfg_t;

    job_t          exp_job[$];
    cfg_t          exp_cfg[$];
    int            exp_err[$];
    bit            model_loaded;
    bit            chain_known;
    logic [CW-1:0] model_chain;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor state
    int            m_takes, m_rounds, m_drain, m_other, m_span, m_cfg_n;
    bit            m_active, m_ready_next;
    logic [CW-1:0] m_bits;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            m_takes = 0; m_rounds = 0; m_drain = 0; m_other = 0; m_span = 0;
            m_cfg_n = 0; m_active = 0; m_ready_next = 0; m_bits = '0;
        end else begin
            if (m_ready_next) check("ready_after_result", 64'(job_ready), 64'(1'b1));
            m_ready_next = 0;

            if (cfg_shift_en) begin
                m_bits = {m_bits[CW-2:0], cfg_serial_out};
                m_cfg_n++;
                check("shift_cycle_outputs", 64'({cfg_busy, job_ready, operand_take, opmode}),
                      64'({1'b1, 1'b0, 1'b0, 9'h020}));
            end
            if (cfg_done) begin
                check("cfg_done_expected", 64'(exp_cfg.size() != 0), 64'(1'b1));
                if (exp_cfg.size() != 0) begin
                    cfg_t c;
                    c = exp_cfg.pop_front();
                    check("cfg_shift_count", 64'(m_cfg_n), 64'(CW));
                    check("cfg_serial_stream", 64'(m_bits), 64'(c.word));
                    check("cfg_loaded_at_done", 64'({cfg_loaded, cfg_busy}), 64'(2'b10));
                    if (c.chk) check("cfg_prev", 64'(cfg_prev), 64'(c.prev));
                end
                m_cfg_n = 0;
            end

            if (operand_take) begin
                check("take_expected", 64'(exp_job.size() != 0), 64'(1'b1));
                check("take_opmode", 64'({job_ready, opmode}),
                      64'({1'b0, (m_active ? 9'h025 : 9'h005)}));
                if (!m_active) begin
                    m_active = 1; m_span = 0;
                end else begin
                    m_span++;
                end
                m_takes++;
            end else if (m_active) begin
                m_span++;
                if (opmode == 9'h120 && m_drain == 0 && m_rounds == 0) m_rounds++;
                else if (opmode == 9'h020) m_drain++;
                else m_other++;
            end

            if (result_valid) begin
                check("result_valid_expected", 64'(exp_job.size() != 0), 64'(1'b1));
                if (exp_job.size() != 0) begin
                    job_t j;
                    j = exp_job.pop_front();
                    check("job_take_count", 64'(m_takes), 64'(j.len));
                    check("job_round_cycles", 64'(m_rounds), 64'(j.rnd));
                    check("job_drain_cycles", 64'({m_drain, m_other}), {32'(PL), 32'd0});
                    check("job_latency", 64'(m_span), 64'(j.len + int'(j.rnd) + PL - 1));
                end
                m_takes = 0; m_rounds = 0; m_drain = 0; m_other = 0; m_span = 0;
                m_active = 0; m_ready_next = 1;
            end

            if (job_err) begin
                check("job_err_expected", 64'(exp_err.size() != 0), 64'(1'b1));
                if (exp_err.size() != 0) void'(exp_err.pop_front());
                check("job_err_no_change", 64'({opmode, job_ready, operand_take, cfg_busy}),
                      64'({9'h020, 1'b1, 1'b0, 1'b0}));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!job_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!job_ready) check("ready_timeout", 64'(job_ready), 64'(1'b1));
    endtask

    // Applies one IDLE request and predicts its outcome from the arbitration rules.
    task automatic issue(input bit ld, input logic [CW-1:0] w, input bit st, input int len, input bit rnd);
        wait_ready();
        if (ld) begin
            exp_cfg.push_back('{word: w, prev: model_chain, chk: chain_known});
            model_chain  = w;
            chain_known  = 1;
            model_loaded = 1;
        end else if (st) begin
            if (len == 0 || (rnd && !model_loaded)) exp_err.push_back(1);
            else exp_job.push_back('{len: len, rnd: rnd});
        end
        cfg_load  = ld;
        cfg_word  = w;
        job_start = st;
        job_len   = LW'(len);
        job_round = rnd;
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        job_start = 1'b0;
    endtask

    task automatic drain_queues();
        int n = 0;
        while ((exp_job.size() != 0 || exp_cfg.size() != 0 || exp_err.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("pending_jobs", 64'(exp_job.size()), 64'd0);
        check("pending_cfgs", 64'(exp_cfg.size()), 64'd0);
        check("pending_errs", 64'(exp_err.size()), 64'd0);
    endtask

    task automatic abort_checks(input string tag);
        check({tag, "_opmode"}, 64'(opmode), 64'(9'h020));
        check({tag, "_strobes"}, 64'({cfg_busy, cfg_done, cfg_shift_en, cfg_serial_out, job_ready,
                                      job_err, operand_take, result_valid}), 64'd0);
        check({tag, "_cfg_loaded"}, 64'(cfg_loaded), 64'd0);
        check({tag, "_cfg_prev"}, 64'(cfg_prev), 64'd0);
    endtask

    initial begin
        chain       = CW'({$urandom, $urandom});
        model_chain = chain;
        chain_known = 1;
        model_loaded = 0;

        repeat (3) @(negedge clk);
        abort_checks("reset");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(job_ready), 64'(1'b1));

        issue(0, '0, 1, 5, 1);                       // rounding before any load
        issue(0, '0, 1, 0, 0);                       // zero-length job
        issue(1, 48'hA5A5_0000_FFFF, 0, 0, 0);
        issue(1, 48'h1, 0, 0, 0);
        issue(0, '0, 1, 3, 0);
        issue(0, '0, 1, 1, 1);
        issue(1, CW'({$urandom, $urandom}), 1, 4, 0); // load wins, job dropped silently
        issue(0, '0, 1, 255, 1);

        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 1) issue(1, CW'({$urandom, $urandom}), 0, 0, 0);
            else if (r == 2) issue(1, CW'({$urandom, $urandom}), 1, $urandom_range(1, 20), 1'($urandom));
            else if (r == 3) issue(0, '0, 1, 0, 1'($urandom));
            else if (r == 9) issue(0, '0, 1, $urandom_range(200, 255), 1'($urandom));
            else issue(0, '0, 1, $urandom_range(1, 12), 1'($urandom));
        end
        drain_queues();

        // Reset in the middle of a configuration shift.
        issue(1, CW'({$urandom, $urandom}), 0, 0, 0);
        repeat (19) @(posedge clk);
        #2 reset = 1'b1;
        exp_job.delete(); exp_cfg.delete(); exp_err.delete();
        #1 abort_checks("abort_shift");
        @(negedge clk);
        reset = 1'b0;
        model_loaded = 0;
        chain_known  = 0;
        issue(0, '0, 1, 2, 1);

        // Reset in the middle of a MAC job.
        issue(0, '0, 1, 50, 0);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        exp_job.delete(); exp_cfg.delete(); exp_err.delete();
        #1 abort_checks("abort_mac");
        @(negedge clk);
        reset = 1'b0;
        model_loaded = 0;
        issue(0, '0, 1, 3, 1);

        issue(1, CW'({$urandom, $urandom}), 0, 0, 0);
        issue(1, 48'h8000_0000_0001, 0, 0, 0);
        issue(0, '0, 1, 2, 1);
        drain_queues();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xyzw_mac_sequencer.md
Name: xyzw_mac_sequencer

Overview:
- Control block for the XYZW operand-select stage of the DSP slice.
- Serially loads the 48-bit rounding constant (RND) into the stage's configuration shift chain and captures the previous chain contents.
- Sequences OPMODE for N-term multiply-accumulate jobs, with an optional final rounding cycle.
- Sits between the tile-level job/config interface and the XYZW stage plus P register.

Parameters:
- CFG_WIDTH, 48, length of the RND configuration chain.
- LEN_WIDTH, 8, width of job_len (max 255 products per job).
- PIPE_LAT, 2, cycles from an OPMODE cycle to P holding its result (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  request to load cfg_word into the RND chain.
- cfg_word  in  CFG_WIDTH  RND value to load.
- cfg_busy  out  1  high while the chain is shifting.
- cfg_done  out  1  one-cycle pulse when the load completes.
- cfg_prev  out  CFG_WIDTH  previous RND contents captured during the last load.
- cfg_loaded  out  1  RND holds a value written since reset.
- cfg_shift_en  out  1  drives configuration_enable.
- cfg_serial_out  out  1  drives configuration_input.
- cfg_serial_in  in  1  from configuration_output.
- job_start  in  1  request to start a MAC job.
- job_len  in  LEN_WIDTH  number of products to accumulate.
- job_round  in  1  append a rounding cycle (W=RND).
- job_ready  out  1  high only in IDLE.
- job_err  out  1  one-cycle pulse when a job request is rejected.
- opmode  out  9  to the XYZW stage: [1:0]=X, [3:2]=Y, [6:4]=Z, [8:7]=W.
- operand_take  out  1  M1/M2 consumed this cycle.
- result_valid  out  1  one-cycle pulse; P holds the final result.

Behaviour:
- States: IDLE, CFG_SHIFT, MAC_FIRST, MAC_ACC, ROUND, DRAIN.
- Reset (asynchronous): state=IDLE, opmode=9'h020, cfg_prev=0, all other outputs 0, counters 0.
  - Reset mid-operation aborts immediately and clears cfg_loaded (the chain is not trusted).
- OPMODE encodings:
  - IDLE, CFG_SHIFT, DRAIN: 9'h020 (Z=P, hold P).
  - MAC_FIRST: 9'h005 (X=M1, Y=M2, Z=0, W=0).
  - MAC_ACC: 9'h025 (X=M1, Y=M2, Z=P).
  - ROUND: 9'h120 (W=RND, Z=P, X=Y=0).
- Outputs are registered: opmode and strobes change on the clock edge that enters the state.
- IDLE arbitration, in priority order:
  - cfg_load wins over job_start in the same cycle; the job request is dropped with no job_err.
  - job_start with job_len=0 -> job_err pulse, stay IDLE.
  - job_start with job_round=1 and cfg_loaded=0 -> job_err pulse, stay IDLE.
  - Otherwise latch job_len and job_round, then go to MAC_FIRST.
- CFG_SHIFT: cfg_word is latched on accept; CFG_WIDTH cycles follow.
  - Each cycle: cfg_shift_en=1, cfg_busy=1, cfg_serial_out = shift-register MSB (MSB first), so the chain equals cfg_word afterwards.
  - Each cycle: cfg_prev <= {cfg_prev[CFG_WIDTH-2:0], cfg_serial_in}.
  - After the last shift: cfg_done pulse, cfg_loaded=1, return to IDLE.
  - cfg_load and job_start are ignored while in CFG_SHIFT.
- MAC: MAC_FIRST lasts 1 cycle, then MAC_ACC for job_len-1 cycles.
  - operand_take=1 in every MAC cycle, so exactly job_len cycles assert it.
  - job_len=1 skips MAC_ACC.
  - Then ROUND (1 cycle, operand_take=0) if job_round=1, else DRAIN.
- DRAIN: PIPE_LAT cycles.
  - result_valid pulses in the last DRAIN cycle, i.e. PIPE_LAT cycles after the last issue cycle.
  - Next state is IDLE; a new job is accepted no earlier than the following cycle.
- job_len=2^LEN_WIDTH-1 must run without counter wrap.

Test Plan:
- Reset, then cfg_load with cfg_word=48'hA5A5_0000_FFFF -> 48 cycles of cfg_shift_en; the serial out stream is the word MSB first; cfg_done at cycle 49; cfg_loaded=1.
  - Reload with 48'h1 -> cfg_prev=48'hA5A5_0000_FFFF.
- Job job_len=3, job_round=0 -> opmode 005, 025, 025 with operand_take=1 each cycle; then 020 for 2 cycles; result_valid in the 2nd DRAIN cycle; job_ready back the cycle after.
- Job job_len=1, job_round=1 after a config load -> opmode 005, then 120, then DRAIN; result_valid 3 cycles after start.
- job_len=0, or job_round=1 right after reset -> job_err pulse, no opmode change, state IDLE.
- cfg_load and job_start in the same IDLE cycle -> config shift runs; job dropped; no job_err.
- Assert reset in the middle of a shift (cycle 20) and in the middle of a MAC job -> opmode=020, all strobes 0, cfg_loaded=0 immediately; a fresh job with job_round=1 is rejected.
